// File: rtl/calc_pkg.sv
// Shared types for the calculator front-end and core: function codes, sequencer states, command record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc_pkg;

    // Default operand width of the calculator datapath.
    localparam int CALC_W = 8;

    typedef enum logic [1:0] {
        FCT_ADD = 2'b00,
        FCT_SUB = 2'b01,
        FCT_MUL = 2'b10,
        FCT_DIV = 2'b11
    } fct_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_state_e;

    // Command record at the default width, as seen by the core.
    typedef struct packed {
        logic [CALC_W-1:0] a;
        logic [CALC_W-1:0] b;
        fct_e              fct;
    } cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Small in-order command FIFO with registered pointers and storage; pop data is read straight from storage.
// Latency: an entry pushed on edge N can be popped on edge N+1 (no same-cycle pass-through).
// Backpressure: full blocks pushes, empty blocks pops; a push and a pop in the same cycle both take effect.
module calc_cmd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The extra top bit tells full (wrap bits differ) from empty (pointers identical).
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset drops everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Command front-end for the calculator core: buffers commands, issues them one at a time, returns res/rem/err.
// Latency: accept E0, pop E1, start E1..E2, response valid on the edge sampling done; div-by-zero responds after E1.
// Backpressure: cmd_ready_o = FIFO not full; a pending response blocks further issues until rsp_ready_i.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int width   = CALC_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [width-1:0]     cmd_a_i,
    input  logic [width-1:0]     cmd_b_i,
    input  logic [1:0]           cmd_fct_i,
    output logic                 calc_start_o,
    output logic [width-1:0]     calc_a_o,
    output logic [width-1:0]     calc_b_o,
    output logic [1:0]           calc_fct_o,
    input  logic [2*width-1:0]   calc_res_i,
    input  logic [2*width-1:0]   calc_rem_i,
    input  logic                 calc_done_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [2*width-1:0]   rsp_res_o,
    output logic [2*width-1:0]   rsp_rem_o,
    output logic                 rsp_err_o,
    output logic                 busy_o
);

    localparam int              WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

    // Same layout as calc_pkg::cmd_t, sized by this instance's operand width.
    typedef struct packed {
        logic [width-1:0] a;
        logic [width-1:0] b;
        fct_e             fct;
    } seq_cmd_t;

    seq_cmd_t           fifo_din;
    seq_cmd_t           fifo_dout;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               div_zero;

    seq_state_e         state;
    seq_state_e         state_nxt;
    logic [WDW-1:0]     wdog;

    logic               rsp_ld;
    logic [2*width-1:0] rsp_res_nxt;
    logic [2*width-1:0] rsp_rem_nxt;
    logic               rsp_err_nxt;

    assign fifo_din  = '{a: cmd_a_i, b: cmd_b_i, fct: fct_e'(cmd_fct_i)};
    assign fifo_push = cmd_valid_i && !fifo_full;

    calc_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (seq_cmd_t)
    ) u_fifo (
        .clk   (clock_i),
        .rst_n (reset_i),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign div_zero     = (fifo_dout.fct == FCT_DIV) && (fifo_dout.b == '0);
    assign cmd_ready_o  = !fifo_full;
    assign calc_start_o = (state == ISSUE);
    assign rsp_valid_o  = (state == RESP);
    assign busy_o       = (state != IDLE) || !fifo_empty;

    // Sequencer state register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, FIFO pop and the response value to capture on leaving IDLE/WAIT.
    always_comb begin
        state_nxt   = state;
        fifo_pop    = 1'b0;
        rsp_ld      = 1'b0;
        rsp_res_nxt = '0;
        rsp_rem_nxt = '0;
        rsp_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (div_zero) begin
                        // Never reaches the core: answer straight away with the dividend as remainder.
                        state_nxt   = RESP;
                        rsp_ld      = 1'b1;
                        rsp_err_nxt = 1'b1;
                        rsp_res_nxt = '1;
                        rsp_rem_nxt = {{width{1'b0}}, fifo_dout.a};
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // done is checked first so it wins over a coincident timeout.
                if (calc_done_i) begin
                    state_nxt   = RESP;
                    rsp_ld      = 1'b1;
                    rsp_res_nxt = calc_res_i;
                    rsp_rem_nxt = (calc_fct_o == FCT_DIV) ? calc_rem_i : '0;
                end else if (wdog == WD_LAST) begin
                    state_nxt   = RESP;
                    rsp_ld      = 1'b1;
                    rsp_err_nxt = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand registers: loaded on pop, held until the next pop so the core sees them stable.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            calc_a_o   <= '0;
            calc_b_o   <= '0;
            calc_fct_o <= '0;
        end else if (fifo_pop) begin
            calc_a_o   <= fifo_dout.a;
            calc_b_o   <= fifo_dout.b;
            calc_fct_o <= fifo_dout.fct;
        end
    end

    // Watchdog: cleared while issuing, counts every WAIT cycle.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wdog <= '0;
        end else if (state == ISSUE) begin
            wdog <= '0;
        end else if (state == WAIT) begin
            wdog <= wdog + WDW'(1);
        end
    end

    // Response registers: captured once per command and held through RESP.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rsp_res_o <= '0;
            rsp_rem_o <= '0;
            rsp_err_o <= 1'b0;
        end else if (rsp_ld) begin
            rsp_res_o <= rsp_res_nxt;
            rsp_rem_o <= rsp_rem_nxt;
            rsp_err_o <= rsp_err_nxt;
        end
    end

endmodule
